// File: rtl/pe_pkg.sv
// Shared definitions for the priority encoder / 7-segment front-end.
//   NUM_REQ  : number of request lines feeding the encoder
//   IDX_W    : width of an encoder index (ack_idx)
//   SEG_W    : number of 7-segment outputs (segments a..g)
//   seg_of() : digit -> segment pattern table used by the decoder stage
package pe_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int SEG_W   = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Active-high segments, bit order {g,f,e,d,c,b,a}. Non-decimal codes blank.
  function automatic seg_t seg_of(input logic [3:0] digit);
    seg_t seg;
    case (digit)
      4'd0:    seg = 7'h3f;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5b;
      4'd3:    seg = 7'h4f;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6d;
      4'd6:    seg = 7'h7d;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7f;
      4'd9:    seg = 7'h6f;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit synchroniser + debouncer.
//   clk    : clock, all state on rising edge
//   rst    : asynchronous active-high reset
//   raw    : raw asynchronous input
//   stable : debounced level (registered)
// The raw input passes through two flops (s1 -> s2). The stable level only
// follows s2 after s2 has disagreed with it for DB_CYCLES consecutive edges;
// any agreement in between restarts the count, so short glitches are dropped.
module debounce_bit #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // DB_CYCLES-th consecutive disagreement: accept the new level.
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_debounce_latch.sv
// Input front-end for the 8-bit priority encoder.
//   clk      : clock, all state on rising edge
//   rst      : asynchronous active-high reset
//   btn      : raw button/switch inputs, bit 7 = highest priority
//   ack      : clear the request selected by ack_idx this cycle
//   ack_idx  : index of the request to clear
//   clr_all  : clear every request this cycle
//   data     : sticky request vector to the encoder
//   stable   : debounced level of each input
//   pending  : OR of data, registered alongside it
// Each input is debounced; each debounced rising edge sets a sticky request
// bit that stays set until it is cleared by ack or clr_all.
//
// Control strobes: ack and clr_all are level strobes sampled on every rising
// edge with no ready/stall; a strobe held for N edges acts N times. clr_all
// covers every bit, so ack alongside clr_all adds nothing.
module request_debounce_latch
  import pe_pkg::*;
#(
  parameter int WIDTH     = NUM_REQ,  // only NUM_REQ (8) is supported
  parameter int DB_CYCLES = 16        // must be >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             clr_all,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] stable,
  output logic             pending
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] data_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (btn[i]),
      .stable (stable[i])
    );
  end

  // Set has priority over clear so a press landing on a clear is never lost.
  always_comb begin
    rise      = stable & ~stable_d;
    clr       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      clr[i] = clr_all | (ack & (ack_idx == IDX_W'(i)));
    end
    data_next = rise | (data & ~clr);
  end

  // stable_d is cleared by reset, so an input held high across reset
  // re-qualifies and then registers as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '0;
      data     <= '0;
      pending  <= 1'b0;
    end else begin
      stable_d <= stable;
      data     <= data_next;
      pending  <= |data_next;
    end
  end

endmodule
